// File: rtl/ram_bist_master.sv
// Write/read-back BIST initiator for the 16-bit internal RAM port.
// Define RAM_BIST_LFSR_EN to use a Galois LFSR pattern instead of seed+i.
module ram_bist_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic [15:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] error_count,
  output logic [31:0] first_error_addr,
  output logic        ram_enable,
  output logic        ram_write,
  output logic [31:0] ram_addr,
  output logic [15:0] ram_data_out,
  input  logic [15:0] ram_data_in
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // WRITE | writing P(i) to base+i
  // READ  | issuing reads; address and expected data enter compare pipe
  // DRAIN | no RAM access; remaining compares retire
  // DONE  | one-cycle done pulse; results valid

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [15:0] pat_first(input logic [15:0] s);
`ifdef RAM_BIST_LFSR_EN
    pat_first = (s == 16'h0000) ? 16'hACE1 : s;
`else
    pat_first = s;
`endif
  endfunction

  function automatic logic [15:0] pat_next(input logic [15:0] p);
`ifdef RAM_BIST_LFSR_EN
    pat_next = {1'b0, p[15:1]} ^ (p[0] ? 16'hB400 : 16'h0000);
`else
    pat_next = p + 16'd1;
`endif
  endfunction

  state_t      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [15:0] count_q, count_d;
  logic [15:0] seed_q, seed_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] pat_q, pat_d;
  logic [1:0]  drain_q, drain_d;
  logic [15:0] err_q, err_d;
  logic [31:0] first_q, first_d;
  logic        pass_q, pass_d;

  logic        pipe_vld_q  [READ_LATENCY];
  logic        pipe_vld_d  [READ_LATENCY];
  logic [31:0] pipe_addr_q [READ_LATENCY];
  logic [31:0] pipe_addr_d [READ_LATENCY];
  logic [15:0] pipe_exp_q  [READ_LATENCY];
  logic [15:0] pipe_exp_d  [READ_LATENCY];

  logic        mismatch;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    seed_d   = seed_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    pat_d    = pat_q;
    drain_d  = drain_q;
    err_d    = err_q;
    first_d  = first_q;
    pass_d   = pass_q;
    mismatch = 1'b0;

    pipe_vld_d[0]  = (state_q == S_READ);
    pipe_addr_d[0] = addr_q;
    pipe_exp_d[0]  = pat_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
      pipe_exp_d[i]  = pipe_exp_q[i-1];
    end

    // Oldest pipe stage lines up with the data the RAM returns this cycle.
    if (pipe_vld_q[READ_LATENCY-1] && (ram_data_in != pipe_exp_q[READ_LATENCY-1])) begin
      mismatch = 1'b1;
    end
    if (mismatch) begin
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
      if (err_q == 16'h0000) begin
        first_d = pipe_addr_q[READ_LATENCY-1];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = word_count;
          seed_d  = seed;
          addr_d  = base_addr;
          rem_d   = word_count - 16'd1;
          pat_d   = pat_first(seed);
          err_d   = 16'h0000;
          first_d = 32'h0000_0000;
          if (word_count == 16'h0000) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            pass_d  = 1'b0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (rem_q == 16'h0000) begin
          state_d = S_READ;
          addr_d  = base_q;
          rem_d   = count_q - 16'd1;
          pat_d   = pat_first(seed_q);
        end else begin
          addr_d = addr_q + 32'd1;
          rem_d  = rem_q - 16'd1;
          pat_d  = pat_next(pat_q);
        end
      end
      S_READ: begin
        if (rem_q == 16'h0000) begin
          state_d = S_DRAIN;
          drain_d = 2'(READ_LATENCY - 1);
        end else begin
          addr_d = addr_q + 32'd1;
          rem_d  = rem_q - 16'd1;
          pat_d  = pat_next(pat_q);
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = S_DONE;
          pass_d  = (err_d == 16'h0000);
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= 32'h0000_0000;
      count_q <= 16'h0000;
      seed_q  <= 16'h0000;
      addr_q  <= 32'h0000_0000;
      rem_q   <= 16'h0000;
      pat_q   <= 16'h0000;
      drain_q <= 2'd0;
      err_q   <= 16'h0000;
      first_q <= 32'h0000_0000;
      pass_q  <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_addr_q[i] <= 32'h0000_0000;
        pipe_exp_q[i]  <= 16'h0000;
      end
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      seed_q  <= seed_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      pat_q   <= pat_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_d[i];
        pipe_addr_q[i] <= pipe_addr_d[i];
        pipe_exp_q[i]  <= pipe_exp_d[i];
      end
    end
  end

  assign busy             = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign error_count      = err_q;
  assign first_error_addr = first_q;
  // Port outputs are gated so the bus reads all-zero whenever the master is not driving it.
  assign ram_enable       = (state_q == S_WRITE) || (state_q == S_READ);
  assign ram_write        = (state_q == S_WRITE);
  assign ram_addr         = ram_enable ? addr_q : 32'h0000_0000;
  assign ram_data_out     = ram_write ? pat_q : 16'h0000;

endmodule

// File: tb/tb_ram_bist_master.sv
// Directed bench for ram_bist_master (default incrementing pattern, READ_LATENCY=1).
module tb_ram_bist_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic [15:0] seed;
  logic        busy, done, pass;
  logic [15:0] error_count;
  logic [31:0] first_error_addr;
  logic        ram_enable, ram_write;
  logic [31:0] ram_addr;
  logic [15:0] ram_data_out;
  logic [15:0] ram_data_in;

  int errors = 0;
  int checks = 0;

  ram_bist_master #(.READ_LATENCY(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .word_count       (word_count),
    .seed             (seed),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .error_count      (error_count),
    .first_error_addr (first_error_addr),
    .ram_enable       (ram_enable),
    .ram_write        (ram_write),
    .ram_addr         (ram_addr),
    .ram_data_out     (ram_data_out),
    .ram_data_in      (ram_data_in)
  );

  always #5 clk = ~clk;

  // RAM model: 256 words indexed by the low address byte, one-cycle read.
  logic [15:0] mem [256];
  logic        fault_stuck = 1'b0;
  logic        fault_all   = 1'b0;
  logic [15:0] rdata = 16'h0000;
  assign ram_data_in = rdata;

  always @(posedge clk) begin
    if (ram_enable && ram_write) begin
      mem[ram_addr[7:0]] <= ram_data_out;
    end else if (ram_enable) begin
      if (fault_all)
        rdata <= mem[ram_addr[7:0]] ^ 16'hFFFF;
      else if (fault_stuck && ram_addr == 32'h0000_0102)
        rdata <= mem[ram_addr[7:0]] & 16'hFFFE;
      else
        rdata <= mem[ram_addr[7:0]];
    end
  end

  logic [31:0] w_addr [$];
  logic [15:0] w_data [$];
  logic [31:0] r_addr [$];
  int          done_cnt;
  int          busy_at1;
  logic        res_pass;
  logic [15:0] res_err;
  logic [31:0] res_first;

  // Pulses start (cycle 0), logs bus activity, returns the cycle done was seen or -1.
  task automatic run_bist(input logic [31:0] b, input logic [15:0] n, input logic [15:0] s,
                          input int restart_at, output int done_cyc);
    w_addr.delete(); w_data.delete(); r_addr.delete();
    done_cnt = 0; busy_at1 = 0; done_cyc = -1;
    res_pass = 1'b0; res_err = 16'hDEAD; res_first = 32'hDEAD_BEEF;
    base_addr = b; word_count = n; seed = s; start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      if (k == restart_at) begin
        base_addr = 32'h0000_0080; word_count = 16'd1; seed = 16'h5555;
      end
      if (k == 1) busy_at1 = busy;
      if (ram_enable && ram_write) begin
        w_addr.push_back(ram_addr); w_data.push_back(ram_data_out);
      end else if (ram_enable) begin
        r_addr.push_back(ram_addr);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = k; res_pass = pass; res_err = error_count; res_first = first_error_addr;
        end
      end
      if (done_cyc > 0 && k >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%0b exp=0", pass); end
    checks++; if (error_count !== 16'h0) begin errors++; $display("FAIL reset_err got=%h exp=0", error_count); end
    checks++; if (first_error_addr !== 32'h0) begin errors++; $display("FAIL reset_first got=%h exp=0", first_error_addr); end
    checks++; if ({ram_enable, ram_write} !== 2'b00) begin errors++; $display("FAIL reset_en_wr got=%b exp=00", {ram_enable, ram_write}); end
    checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
    checks++; if (ram_data_out !== 16'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", ram_data_out); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc;
    run_bist(32'h100, 16'd4, 16'h1230, -1, dc);
    checks++; if (dc !== 10) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=10", dc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (busy_at1 !== 1) begin errors++; $display("FAIL basic_busy_c1 got=%0d exp=1", busy_at1); end
    checks++; if (res_pass !== 1'b1) begin errors++; $display("FAIL basic_pass got=%0b exp=1", res_pass); end
    checks++; if (res_err !== 16'h0) begin errors++; $display("FAIL basic_err got=%h exp=0", res_err); end
    checks++; if (res_first !== 32'h0) begin errors++; $display("FAIL basic_first got=%h exp=0", res_first); end
    checks++; if (w_addr.size() !== 4 || r_addr.size() !== 4) begin
      errors++; $display("FAIL basic_access_count got=%0d/%0d exp=4/4", w_addr.size(), r_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (w_addr[i] !== 32'h100 + 32'(i) || w_data[i] !== 16'h1230 + 16'(i) || r_addr[i] !== 32'h100 + 32'(i)) begin
          errors++; $display("FAIL basic_word%0d got=%h/%h/%h exp=%h/%h/%h", i, w_addr[i], w_data[i], r_addr[i],
                             32'h100 + 32'(i), 16'h1230 + 16'(i), 32'h100 + 32'(i));
        end
      end
    end
    checks++; if (pass !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_hold got=pass%0b busy%0b exp=pass1 busy0", pass, busy); end
  endtask

  task automatic test_stuck_bit();
    int dc;
    fault_stuck = 1'b1;
    run_bist(32'h100, 16'd4, 16'h0001, -1, dc);
    fault_stuck = 1'b0;
    checks++; if (dc !== 10) begin errors++; $display("FAIL stuck_done_cycle got=%0d exp=10", dc); end
    checks++; if (res_err !== 16'd1) begin errors++; $display("FAIL stuck_err got=%0d exp=1", res_err); end
    checks++; if (res_first !== 32'h102) begin errors++; $display("FAIL stuck_first got=%h exp=00000102", res_first); end
    checks++; if (res_pass !== 1'b0) begin errors++; $display("FAIL stuck_pass got=%0b exp=0", res_pass); end
    checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL stuck_err_hold got=%0d exp=1", error_count); end
  endtask

  task automatic test_zero_length();
    int dc;
    run_bist(32'h200, 16'd0, 16'h9999, -1, dc);
    checks++; if (dc !== 1) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=1", dc); end
    checks++; if (w_addr.size() + r_addr.size() !== 0) begin errors++; $display("FAIL zero_accesses got=%0d exp=0", w_addr.size() + r_addr.size()); end
    checks++; if (res_pass !== 1'b1) begin errors++; $display("FAIL zero_pass got=%0b exp=1", res_pass); end
    checks++; if (res_err !== 16'h0 || res_first !== 32'h0) begin errors++; $display("FAIL zero_cleared got=%h/%h exp=0/0", res_err, res_first); end
  endtask

  task automatic test_addr_wrap();
    int dc;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0001;
    run_bist(32'hFFFF_FFFE, 16'd4, 16'hFFFE, -1, dc);
    checks++; if (dc !== 10 || res_pass !== 1'b1) begin errors++; $display("FAIL wrap_result got=cyc%0d pass%0b exp=cyc10 pass1", dc, res_pass); end
    checks++; if (w_addr.size() !== 4 || r_addr.size() !== 4) begin
      errors++; $display("FAIL wrap_access_count got=%0d/%0d exp=4/4", w_addr.size(), r_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (w_addr[i] !== exp_a[i] || r_addr[i] !== exp_a[i]) begin
          errors++; $display("FAIL wrap_addr%0d got=%h/%h exp=%h", i, w_addr[i], r_addr[i], exp_a[i]);
        end
      end
      checks++; if (w_data[2] !== 16'h0000) begin errors++; $display("FAIL wrap_data2 got=%h exp=0000", w_data[2]); end
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    fault_all = 1'b1;
    run_bist(32'h10, 16'd5, 16'h00F0, 3, dc);
    fault_all = 1'b0;
    checks++; if (dc !== 12) begin errors++; $display("FAIL b2b_done_cycle got=%0d exp=12", dc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (res_err !== 16'd5) begin errors++; $display("FAIL b2b_err got=%0d exp=5", res_err); end
    checks++; if (res_first !== 32'h10) begin errors++; $display("FAIL b2b_first got=%h exp=00000010", res_first); end
    checks++; if (res_pass !== 1'b0) begin errors++; $display("FAIL b2b_pass got=%0b exp=0", res_pass); end
    checks++; if (w_addr.size() !== 5) begin errors++; $display("FAIL b2b_writes got=%0d exp=5", w_addr.size()); end
  endtask

  task automatic test_reset_mid_run();
    int dc;
    int seen_done;
    seen_done = 0;
    base_addr = 32'h40; word_count = 16'd8; seed = 16'h0007; start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || ram_enable !== 1'b0 || ram_write !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle got=busy%0b en%0b wr%0b exp=000", busy, ram_enable, ram_write);
    end
    checks++; if (ram_addr !== 32'h0 || ram_data_out !== 16'h0) begin errors++; $display("FAIL rstmid_bus got=%h/%h exp=0/0", ram_addr, ram_data_out); end
    for (int k = 0; k < 20; k++) begin
      if (done || ram_enable) seen_done++;
      @(posedge clk); #1;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rstmid_activity got=%0d exp=0", seen_done); end
    run_bist(32'h40, 16'd8, 16'h0007, -1, dc);
    checks++; if (dc !== 18) begin errors++; $display("FAIL rstmid_rerun_cycle got=%0d exp=18", dc); end
    checks++; if (res_pass !== 1'b1 || res_err !== 16'h0) begin errors++; $display("FAIL rstmid_rerun got=pass%0b err%0d exp=pass1 err0", res_pass, res_err); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    base_addr = 32'h0; word_count = 16'h0; seed = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic();
    test_stuck_bit();
    test_zero_length();
    test_addr_wrap();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
